// File: rtl/ahb3lite_sram_slave.sv
// AHB3-Lite single-port SRAM slave.
//
// Terminates AHB-Lite transfers on a word-organised internal memory. Each accepted
// address phase is registered. Legal transfers then get WAIT_STATES wait cycles
// followed by one final data-phase cycle. Illegal transfers get a two-cycle ERROR
// response. Writes commit with byte-lane strobes at the edge that ends the data phase.
//
// Ports:
//   HCLK       bus clock; all state changes on the rising edge
//   HRESET     asynchronous, active-high reset
//   HSEL       slave select
//   HADDR      byte address
//   HWRITE     1 = write, 0 = read
//   HTRANS     IDLE/BUSY/NONSEQ/SEQ; only NONSEQ and SEQ start a data phase
//   HSIZE      byte / halfword / word
//   HBURST     ignored (every beat carries its own address)
//   HPROT      ignored
//   HWDATA     write data, valid during the data phase
//   HREADY     bus ready from the interconnect
//   HREADYOUT  slave ready
//   HRESP      0 OKAY, 1 ERROR
//   HRDATA     read data, zero outside a read data phase

module ahb3lite_sram_slave #(
    parameter int unsigned HADDR_SIZE  = 32,
    parameter int unsigned HDATA_SIZE  = 32,
    parameter int unsigned MEM_DEPTH   = 256,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic                  HSEL,
    input  logic [HADDR_SIZE-1:0] HADDR,
    input  logic                  HWRITE,
    input  logic [1:0]            HTRANS,
    input  logic [2:0]            HSIZE,
    input  logic [2:0]            HBURST,
    input  logic [3:0]            HPROT,
    input  logic [HDATA_SIZE-1:0] HWDATA,
    input  logic                  HREADY,
    output logic                  HREADYOUT,
    output logic                  HRESP,
    output logic [HDATA_SIZE-1:0] HRDATA
);

    localparam int unsigned IDX_W  = HADDR_SIZE - 2;
    localparam int unsigned MEM_AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [3:0]  CNT_INIT = 4'(WAIT_STATES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_DATA,
        S_ERR1,
        S_ERR2
    } state_t;

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [MEM_AW-1:0]   idx_q, idx_d;
    logic                wr_q, wr_d;
    logic [3:0]          be_q, be_d;

    logic                accept;
    logic                illegal;
    logic [3:0]          be_new;
    logic                rd_active;

    logic [HDATA_SIZE-1:0] mem [MEM_DEPTH];

    logic unused_inputs;
    assign unused_inputs = ^{HBURST, HPROT, HTRANS[0]};

    // BUSY and IDLE have HTRANS[1] clear and never start a data phase.
    assign accept = HSEL & HREADY & HTRANS[1];

    always_comb begin
        illegal = 1'b0;
        if (HADDR[HADDR_SIZE-1:2] >= IDX_W'(MEM_DEPTH)) begin
            illegal = 1'b1;
        end
        case (HSIZE)
            3'b000:  ;
            3'b001:  if (HADDR[0]) illegal = 1'b1;
            3'b010:  if (HADDR[1:0] != 2'b00) illegal = 1'b1;
            default: illegal = 1'b1;
        endcase
    end

    // Little-endian lane strobes; only meaningful for legal sizes.
    always_comb begin
        be_new = 4'b1111;
        case (HSIZE[1:0])
            2'b00:   be_new = 4'b0001 << HADDR[1:0];
            2'b01:   be_new = HADDR[1] ? 4'b1100 : 4'b0011;
            default: be_new = 4'b1111;
        endcase
    end

    // State register
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            idx_q   <= '0;
            wr_q    <= 1'b0;
            be_q    <= 4'b0000;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            wr_q    <= wr_d;
            be_q    <= be_d;
        end
    end

    // Next state
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        wr_d    = wr_q;
        be_d    = be_q;
        case (state_q)
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = S_DATA;
                end
            end
            S_ERR1: state_d = S_ERR2;
            default: begin
                // S_IDLE, S_DATA, S_ERR2: HREADYOUT is high, a new address may be taken.
                if (accept) begin
                    idx_d = HADDR[MEM_AW+1:2];
                    wr_d  = HWRITE;
                    be_d  = be_new;
                    if (illegal) begin
                        state_d = S_ERR1;
                    end else if (WAIT_STATES == 0) begin
                        state_d = S_DATA;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    // Outputs
    always_comb begin
        HREADYOUT = 1'b1;
        HRESP     = 1'b0;
        case (state_q)
            S_WAIT: HREADYOUT = 1'b0;
            S_ERR1: begin
                HREADYOUT = 1'b0;
                HRESP     = 1'b1;
            end
            S_ERR2: HRESP = 1'b1;
            default: ;
        endcase
    end

    // Read is a plain array lookup: a write committed at the edge that accepts a
    // read is already visible, so no forwarding path is needed.
    assign rd_active = ((state_q == S_WAIT) || (state_q == S_DATA)) && !wr_q;
    assign HRDATA    = rd_active ? mem[idx_q] : '0;

    // Memory contents are deliberately not reset. A reset forces S_IDLE, which
    // drops a pending write.
    always_ff @(posedge HCLK) begin
        if ((state_q == S_DATA) && wr_q) begin
            for (int b = 0; b < 4; b++) begin
                if (be_q[b]) begin
                    mem[idx_q][8*b +: 8] <= HWDATA[8*b +: 8];
                end
            end
        end
    end

endmodule
